// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// word/register widths, M-extension funct3 codes, FSM state encodings and
// an operand signedness decoder.
package ex_muldiv_pkg;

    localparam int unsigned WORD_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned FUNCT3_WIDTH   = 3;

    // M-extension funct3 codes
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    // Returns {rs1_signed, rs2_signed} for a given funct3.
    function automatic logic [1:0] operand_signs(input logic [2:0] f3);
        logic [1:0] signs;
        case (f3)
            F3_MULH, F3_DIV, F3_REM:              signs = 2'b11;
            F3_MULHSU:                            signs = 2'b10;
            F3_MUL, F3_MULHU, F3_DIVU, F3_REMU:   signs = 2'b00;
            default:                              signs = 2'b00;
        endcase
        return signs;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Execute-stage muldiv interface.
// master: ID/EX side (drives start/operands/flush, receives stall/result).
// slave : the muldiv unit.
interface ex_muldiv_if
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = WORD_WIDTH
);
    logic                      start_i;
    logic [FUNCT3_WIDTH-1:0]   funct3_i;
    logic [XLEN-1:0]           rs1_data_i;
    logic [XLEN-1:0]           rs2_data_i;
    logic [REG_ADDR_WIDTH-1:0] rd_i;
    logic                      flush_i;
    logic                      busy_o;
    logic                      done_o;
    logic [XLEN-1:0]           result_o;
    logic [REG_ADDR_WIDTH-1:0] rd_o;

    modport master (
        output start_i, funct3_i, rs1_data_i, rs2_data_i, rd_i, flush_i,
        input  busy_o, done_o, result_o, rd_o
    );

    modport slave (
        input  start_i, funct3_i, rs1_data_i, rs2_data_i, rd_i, flush_i,
        output busy_o, done_o, result_o, rd_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit (execute stage).
// Ports: clk, rst_n (async active-low), bus (ex_muldiv_if.slave):
//   start_i/funct3_i/rs1_data_i/rs2_data_i/rd_i/flush_i in,
//   busy_o (stall), done_o (1-cycle pulse), result_o, rd_o out.
// Operates on magnitudes for XLEN iterations (shift-add or restoring
// divide), then applies the recorded sign in FIX.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = WORD_WIDTH
)(
    input  logic         clk,
    input  logic         rst_n,
    ex_muldiv_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]                state_q,  state_d;
    logic [CNT_W-1:0]          cnt_q,    cnt_d;
    logic [2:0]                f3_q,     f3_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,     rd_d;
    logic                      neg_q,    neg_d;
    logic [XLEN-1:0]           opb_q,    opb_d;
    logic [ACC_W-1:0]          acc_q,    acc_d;
    logic [XLEN-1:0]           res_q,    res_d;
    logic                      busy_q,   busy_d;
    logic                      done_q,   done_d;

    logic [1:0]      signs;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            accept;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   mul_sum, div_diff;
    logic [ACC_W-1:0] prod_fix;
    logic [XLEN-1:0] div_sel, div_fix, fix_res;

    // Accept-time operand decode and special-case detection
    always_comb begin
        signs  = operand_signs(bus.funct3_i);
        a_neg  = signs[1] & bus.rs1_data_i[XLEN-1];
        b_neg  = signs[0] & bus.rs2_data_i[XLEN-1];
        a_mag  = a_neg ? -bus.rs1_data_i : bus.rs1_data_i;
        b_mag  = b_neg ? -bus.rs2_data_i : bus.rs2_data_i;
        accept = bus.start_i && !bus.flush_i &&
                 ((state_q == ST_IDLE) || (state_q == ST_DONE));
        div_zero = bus.funct3_i[2] && (bus.rs2_data_i == '0);
        div_ovf  = ((bus.funct3_i == F3_DIV) || (bus.funct3_i == F3_REM)) &&
                   (bus.rs1_data_i == INT_MIN) && (bus.rs2_data_i == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = bus.funct3_i[1] ? bus.rs1_data_i : '1;
        end else if (div_ovf) begin
            special_res = bus.funct3_i[1] ? '0 : INT_MIN;
        end
    end

    // Iteration datapath and final sign/selection
    always_comb begin
        // Multiply: multiplier sits in acc low half, shifted out LSB-first
        mul_sum  = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        // Divide: {rem,quo} shifted left by one; trial subtract on top 33 bits
        div_diff = acc_q[ACC_W-1:XLEN-1] - {1'b0, opb_q};
        prod_fix = neg_q ? -acc_q : acc_q;
        div_sel  = f3_q[1] ? acc_q[ACC_W-1:XLEN] : acc_q[XLEN-1:0];
        div_fix  = neg_q ? -div_sel : div_sel;
        if (f3_q[2]) begin
            fix_res = div_fix;
        end else if (f3_q == F3_MUL) begin
            fix_res = prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[ACC_W-1:XLEN];
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        neg_d   = neg_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        res_d   = res_q;

        if (bus.flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_d = ST_IDLE;
                    if (accept) begin
                        f3_d  = bus.funct3_i;
                        rd_d  = bus.rd_i;
                        cnt_d = '0;
                        if (bus.funct3_i == F3_REM) begin
                            neg_d = a_neg;
                        end else begin
                            neg_d = a_neg ^ b_neg;
                        end
                        if (div_zero || div_ovf) begin
                            res_d   = special_res;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_CALC;
                            if (bus.funct3_i[2]) begin
                                acc_d = {{XLEN{1'b0}}, a_mag};
                                opb_d = b_mag;
                            end else begin
                                acc_d = {{XLEN{1'b0}}, b_mag};
                                opb_d = a_mag;
                            end
                        end
                    end
                end
                ST_CALC: begin
                    if (f3_q[2]) begin
                        if (!div_diff[XLEN]) begin
                            acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_d = {acc_q[ACC_W-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    res_d   = fix_res;
                    state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            neg_q   <= 1'b0;
            opb_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            neg_q   <= neg_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = res_q;
    assign bus.rd_o     = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed testbench for ex_muldiv: hand-computed results, done/busy
// cycle positions, special cases, flush, ignored start, reset, back-to-back.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    ex_muldiv_if #(.XLEN(32)) bus ();

    ex_muldiv #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] MASK_BUSY_NORM = 64'h0000_0003_FFFF_FFFE; // cycles 1..33
    localparam logic [63:0] MASK_DONE_NORM = 64'h0000_0004_0000_0000; // cycle 34
    localparam logic [63:0] MASK_DONE_SPEC = 64'h0000_0000_0000_0002; // cycle 1

    task automatic drive_op(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] r);
        bus.start_i    = 1'b1;
        bus.funct3_i   = f3;
        bus.rs1_data_i = a;
        bus.rs2_data_i = b;
        bus.rd_i       = r;
    endtask

    // Start sampled at edge E0; returns after E0 with start deasserted.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r);
        @(negedge clk);
        drive_op(f3, a, b, r);
        @(posedge clk);
        #1 bus.start_i = 1'b0;
    endtask

    // Samples cycles 1..ncyc mid-cycle; optional flush / stray start injection.
    task automatic run_window(input int ncyc, input int flush_cyc, input int inj_cyc,
                              output logic [63:0] busy_mask, output logic [63:0] done_mask,
                              output logic [31:0] res, output logic [4:0] rdv);
        bit got;
        busy_mask = '0;
        done_mask = '0;
        res       = '0;
        rdv       = '0;
        got       = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            busy_mask[6'(c)] = bus.busy_o;
            done_mask[6'(c)] = bus.done_o;
            if (bus.done_o === 1'b1 && !got) begin
                got = 1'b1;
                res = bus.result_o;
                rdv = bus.rd_o;
            end
            bus.flush_i = (c == flush_cyc);
            if (c == inj_cyc) drive_op(F3_DIVU, 32'd100, 32'd7, 5'd9);
            else bus.start_i = 1'b0;
        end
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.flush_i = 1'b0; bus.funct3_i = '0;
        bus.rs1_data_i = '0; bus.rs2_data_i = '0; bus.rd_i = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.busy_o, bus.done_o, bus.result_o, bus.rd_o} !== 39'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b res=%h rd=%0d, expected all zero",
                     bus.busy_o, bus.done_o, bus.result_o, bus.rd_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [63:0] bm, dm; logic [31:0] r; logic [4:0] rd;
        issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3);
        run_window(40, 0, 0, bm, dm, r, rd);
        n_vec++;
        if (r !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_result: got %h expected ffffffeb", r); end
        n_vec++;
        if (dm !== MASK_DONE_NORM) begin n_err++; $display("FAIL mul_done_cycle: got mask %h expected %h", dm, MASK_DONE_NORM); end
        n_vec++;
        if (bm !== MASK_BUSY_NORM) begin n_err++; $display("FAIL mul_busy_cycles: got mask %h expected %h", bm, MASK_BUSY_NORM); end
        n_vec++;
        if (rd !== 5'd3) begin n_err++; $display("FAIL mul_rd: got %0d expected 3", rd); end
    endtask

    task automatic test_mul_high();
        logic [63:0] bm, dm; logic [31:0] r; logic [4:0] rd;
        logic [2:0]  ops [3];
        logic [31:0] exp [3];
        ops[0] = F3_MULHU;  exp[0] = 32'hFFFF_FFFE;
        ops[1] = F3_MULH;   exp[1] = 32'h0000_0000;
        ops[2] = F3_MULHSU; exp[2] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
            run_window(40, 0, 0, bm, dm, r, rd);
            n_vec++;
            if (r !== exp[i] || dm !== MASK_DONE_NORM) begin
                n_err++;
                $display("FAIL mulhigh_f3_%0d: got %h done %h expected %h done %h",
                         ops[i], r, dm, exp[i], MASK_DONE_NORM);
            end
        end
    endtask

    task automatic test_div();
        logic [63:0] bm, dm; logic [31:0] r; logic [4:0] rd;
        logic [2:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        logic [31:0] exp [4];
        ops[0] = F3_DIV;  as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2; exp[0] = 32'hFFFF_FFFD;
        ops[1] = F3_REM;  as[1] = 32'hFFFF_FFF9; bs[1] = 32'd2; exp[1] = 32'hFFFF_FFFF;
        ops[2] = F3_DIVU; as[2] = 32'd100;       bs[2] = 32'd7; exp[2] = 32'd14;
        ops[3] = F3_REMU; as[3] = 32'd100;       bs[3] = 32'd7; exp[3] = 32'd2;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 5'(10 + i));
            run_window(40, 0, 0, bm, dm, r, rd);
            n_vec++;
            if (r !== exp[i] || dm !== MASK_DONE_NORM) begin
                n_err++;
                $display("FAIL div_f3_%0d: got %h done %h expected %h done %h",
                         ops[i], r, dm, exp[i], MASK_DONE_NORM);
            end
            n_vec++;
            if (rd !== 5'(10 + i)) begin
                n_err++;
                $display("FAIL div_rd_%0d: got %0d expected %0d", i, rd, 10 + i);
            end
        end
    endtask

    task automatic test_special();
        logic [63:0] bm, dm; logic [31:0] r; logic [4:0] rd;
        logic [2:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        logic [31:0] exp [4];
        ops[0] = F3_DIV; as[0] = 32'd5;         bs[0] = 32'd0;         exp[0] = 32'hFFFF_FFFF;
        ops[1] = F3_REM; as[1] = 32'd5;         bs[1] = 32'd0;         exp[1] = 32'd5;
        ops[2] = F3_DIV; as[2] = 32'h8000_0000; bs[2] = 32'hFFFF_FFFF; exp[2] = 32'h8000_0000;
        ops[3] = F3_REM; as[3] = 32'h8000_0000; bs[3] = 32'hFFFF_FFFF; exp[3] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 5'd7);
            run_window(4, 0, 0, bm, dm, r, rd);
            n_vec++;
            if (r !== exp[i]) begin
                n_err++;
                $display("FAIL special_%0d_result: got %h expected %h", i, r, exp[i]);
            end
            n_vec++;
            if (dm !== MASK_DONE_SPEC || bm !== 64'd0) begin
                n_err++;
                $display("FAIL special_%0d_timing: got done %h busy %h expected done %h busy 0",
                         i, dm, bm, MASK_DONE_SPEC);
            end
        end
    endtask

    task automatic test_flush();
        logic [63:0] bm, dm; logic [31:0] r; logic [4:0] rd;
        issue(F3_DIV, 32'd5, 32'd0, 5'd2);        // sets result_o to ffffffff
        run_window(3, 0, 0, bm, dm, r, rd);
        issue(F3_DIV, 32'd100, 32'd7, 5'd2);
        run_window(40, 10, 0, bm, dm, r, rd);
        n_vec++;
        if (bm !== 64'h0000_0000_0000_07FE) begin
            n_err++; $display("FAIL flush_busy: got mask %h expected 00000000000007fe", bm);
        end
        n_vec++;
        if (dm !== 64'd0) begin
            n_err++; $display("FAIL flush_no_done: got mask %h expected 0", dm);
        end
        n_vec++;
        if (bus.result_o !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL flush_result_held: got %h expected ffffffff", bus.result_o);
        end
    endtask

    task automatic test_ignored_start();
        logic [63:0] bm, dm; logic [31:0] r; logic [4:0] rd;
        issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3);
        run_window(45, 0, 5, bm, dm, r, rd);
        n_vec++;
        if (dm !== MASK_DONE_NORM) begin
            n_err++; $display("FAIL ignstart_done: got mask %h expected %h", dm, MASK_DONE_NORM);
        end
        n_vec++;
        if (r !== 32'hFFFF_FFEB || rd !== 5'd3) begin
            n_err++; $display("FAIL ignstart_result: got %h rd %0d expected ffffffeb rd 3", r, rd);
        end
    endtask

    task automatic test_reset_midop();
        logic [63:0] bm, dm; logic [31:0] r; logic [4:0] rd;
        issue(F3_DIVU, 32'd100, 32'd7, 5'd12);
        for (int c = 1; c <= 20; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.busy_o, bus.done_o, bus.result_o, bus.rd_o} !== 39'd0) begin
            n_err++;
            $display("FAIL midop_reset: got busy=%b done=%b res=%h rd=%0d, expected all zero",
                     bus.busy_o, bus.done_o, bus.result_o, bus.rd_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_window(40, 0, 0, bm, dm, r, rd);
        n_vec++;
        if (dm !== 64'd0 || bm !== 64'd0) begin
            n_err++; $display("FAIL midop_reset_quiet: got done %h busy %h expected 0 0", dm, bm);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] bm, dm; logic [31:0] r; logic [4:0] rd;
        logic        d34;
        logic [31:0] r34;
        issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        d34 = 1'b0;
        r34 = '0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (c == 34) begin
                d34 = bus.done_o;
                r34 = bus.result_o;
                drive_op(F3_DIVU, 32'd100, 32'd7, 5'd6);
            end
        end
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        n_vec++;
        if (d34 !== 1'b1 || r34 !== 32'hFFFF_FFFE) begin
            n_err++; $display("FAIL b2b_first: got done %b res %h expected 1 fffffffe", d34, r34);
        end
        run_window(40, 0, 0, bm, dm, r, rd);
        n_vec++;
        if (dm !== MASK_DONE_NORM) begin
            n_err++; $display("FAIL b2b_second_done: got mask %h expected %h", dm, MASK_DONE_NORM);
        end
        n_vec++;
        if (r !== 32'd14 || rd !== 5'd6) begin
            n_err++; $display("FAIL b2b_second_result: got %h rd %0d expected 0000000e rd 6", r, rd);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_flush();
        test_ignored_start();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
